immdt_extender_pipe: RTL and testbench

Parametrised, pipelined immediate extender with a small output queue. It accepts IN_W-bit immediates plus a mode over a valid/ready handshake. Each immediate is extended to OUT_W bits by one of four rules and buffered in a DEPTH-entry FIFO. The block sits between decode and execute in the multi-cycle CPU and adds zero/sign, upper-load (LUI) and shifted branch-offset modes. A synchronous flush covers branch squash.

---
 rtl/immdt_extender_pipe.sv | 86 ++++++++
 tb/tb_immdt_extender_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/immdt_extender_pipe.sv
// Immediate extender with a small output queue.
// Each accepted immediate is extended to OUT_W bits (zero, sign, upper-load
// or sign-extended-and-shifted) at the input, then held in a DEPTH-entry FIFO.
// Flush empties the queue so that a squashed branch leaves nothing behind.
module immdt_extender_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_immdt,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_immdt,
  output logic [$clog2(DEPTH+1)-1:0] out_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Apply one of the four extension rules to a raw immediate.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                               input logic [1:0]      mode);
    logic signed [OUT_W-1:0] sx;
    sx = OUT_W'($signed(imm));
    case (mode)
      2'd0:    extend = OUT_W'(imm);
      2'd1:    extend = sx;
      2'd2:    extend = {imm, {(OUT_W-IN_W){1'b0}}};
      default: extend = sx <<< SHAMT;
    endcase
  endfunction

  // Advance a queue pointer, wrapping at DEPTH-1 so any depth works.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    wrap_inc = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [CW-1:0]    count;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [OUT_W-1:0] mem_p1 [DEPTH];
  logic [OUT_W-1:0] ext_p0;
  logic             push;
  logic             pop;

  // Stage 0: handshake qualifiers and extension of the incoming immediate.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ext_p0    = extend(in_immdt, in_mode);

  // Queue control: reset beats flush, flush beats any push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage 1: store the already-extended value at the tail.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem_p1[wr_ptr] <= ext_p0;
  end

  // Head entry is driven to zero while empty so the output is never X.
  assign out_immdt = out_valid ? mem_p1[rd_ptr] : '0;
  assign out_count = count;

endmodule

// File: tb/tb_immdt_extender_pipe.sv
// Directed bench for immdt_extender_pipe: default parameters plus a narrow
// instance (IN_W=8, OUT_W=12, DEPTH=3, SHAMT=1) sharing one clock.
module tb_immdt_extender_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Instance A: default parameters.
  logic        a_reset, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0] a_in_immdt;
  logic [1:0]  a_in_mode;
  logic [31:0] a_out_immdt;
  logic [1:0]  a_out_count;

  immdt_extender_pipe dut_a (
    .clk(clk), .reset(a_reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_immdt(a_in_immdt), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_immdt(a_out_immdt), .out_count(a_out_count)
  );

  // Instance B: narrow, three-deep queue.
  logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_immdt;
  logic [1:0]  b_in_mode;
  logic [11:0] b_out_immdt;
  logic [1:0]  b_out_count;

  immdt_extender_pipe #(.IN_W(8), .OUT_W(12), .SHAMT(1), .DEPTH(3)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_immdt(b_in_immdt), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_immdt(b_out_immdt), .out_count(b_out_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push_pop(input logic [15:0] imm, input logic [1:0] mode,
                            input logic [31:0] exp, input string tag);
    a_in_valid = 1'b1; a_in_immdt = imm; a_in_mode = mode; a_out_ready = 1'b0;
    step();
    a_in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    chk(tag, a_out_immdt, exp);
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(a_out_valid), 32'd0);
  endtask

  logic [11:0] exp_q [$];

  initial begin
    a_reset = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_in_immdt = '0; a_in_mode = '0;
    b_reset = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in_immdt = '0; b_in_mode = '0;
    step();
    step();
    a_reset = 1'b0; b_reset = 1'b0;

    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_count", 32'(a_out_count), 32'd0);
    chk("rst_ready", 32'(a_in_ready), 32'd1);
    chk("rst_immdt", a_out_immdt, 32'd0);

    a_push_pop(16'h8001, 2'd1, 32'hFFFF8001, "sign");
    a_push_pop(16'h8001, 2'd0, 32'h00008001, "zero");
    a_push_pop(16'h1234, 2'd2, 32'h12340000, "upper");
    a_push_pop(16'hFFFF, 2'd3, 32'hFFFFFFFC, "shneg");
    a_push_pop(16'h0003, 2'd3, 32'h0000000C, "shpos");

    // Fill, then hold a third push while full.
    a_in_mode = 2'd0;
    a_in_valid = 1'b1; a_in_immdt = 16'h0001; step();
    a_in_immdt = 16'h0002; step();
    chk("full_count", 32'(a_out_count), 32'd2);
    chk("full_ready", 32'(a_in_ready), 32'd0);
    a_in_immdt = 16'h0003; step();
    chk("held_count", 32'(a_out_count), 32'd2);
    chk("held_head", a_out_immdt, 32'h00000001);
    a_in_valid = 1'b0; a_out_ready = 1'b1; step();
    chk("pop1_head", a_out_immdt, 32'h00000002);
    chk("pop1_ready", 32'(a_in_ready), 32'd1);
    step();
    chk("pop2_valid", 32'(a_out_valid), 32'd0);
    a_out_ready = 1'b0;

    // Simultaneous push and pop at count 1.
    a_in_valid = 1'b1; a_in_immdt = 16'h0004; step();
    a_in_immdt = 16'h0005; a_out_ready = 1'b1; step();
    chk("pp_count", 32'(a_out_count), 32'd1);
    chk("pp_head", a_out_immdt, 32'h00000005);
    a_in_valid = 1'b0; step();
    a_out_ready = 1'b0;
    chk("pp_drain", 32'(a_out_count), 32'd0);

    // Flush with two queued entries and an input presented.
    a_in_valid = 1'b1; a_in_immdt = 16'h0006; step();
    a_in_immdt = 16'h0007; step();
    a_flush = 1'b1; a_in_immdt = 16'h0008; step();
    a_flush = 1'b0; a_in_valid = 1'b0;
    chk("fl_valid", 32'(a_out_valid), 32'd0);
    chk("fl_count", 32'(a_out_count), 32'd0);
    chk("fl_ready", 32'(a_in_ready), 32'd1);

    // Flush while not full: the pushed input must be discarded.
    a_in_valid = 1'b1; a_in_immdt = 16'h0009; step();
    a_flush = 1'b1; a_in_immdt = 16'h000A; a_out_ready = 1'b1; step();
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    step();
    chk("fl2_count", 32'(a_out_count), 32'd0);
    a_in_valid = 1'b1; a_in_immdt = 16'h000B; step();
    a_in_valid = 1'b0;
    chk("fl2_head", a_out_immdt, 32'h0000000B);
    chk("fl2_cnt1", 32'(a_out_count), 32'd1);

    // Narrow instance: mode 3 sign-extend then shift.
    chk("b_rst_ready", 32'(b_in_ready), 32'd1);
    b_in_valid = 1'b1; b_in_immdt = 8'h81; b_in_mode = 2'd3; step();
    b_in_valid = 1'b0;
    chk("b_sh", 32'(b_out_immdt), 32'h00000F02);
    b_out_ready = 1'b1; step();
    b_out_ready = 1'b0;

    // Fill all three slots, pop one, then seven push+pop cycles across the wrap.
    b_in_mode = 2'd0; b_in_valid = 1'b1;
    b_in_immdt = 8'h11; step();
    b_in_immdt = 8'h22; step();
    b_in_immdt = 8'h33; step();
    chk("b_full_count", 32'(b_out_count), 32'd3);
    chk("b_full_ready", 32'(b_in_ready), 32'd0);
    b_in_valid = 1'b0; b_out_ready = 1'b1; step();
    exp_q = '{12'h022, 12'h033};
    chk("b_pop_head", 32'(b_out_immdt), 32'(exp_q[0]));
    for (int i = 0; i < 7; i++) begin
      b_in_valid = 1'b1; b_in_immdt = 8'h40 + 8'(i); b_out_ready = 1'b1;
      exp_q.push_back(12'h040 + 12'(i));
      void'(exp_q.pop_front());
      step();
      chk($sformatf("b_wrap_head%0d", i), 32'(b_out_immdt), 32'(exp_q[0]));
      chk($sformatf("b_wrap_cnt%0d", i), 32'(b_out_count), 32'd2);
    end

    // Reset in the middle of traffic.
    b_reset = 1'b1; step();
    b_reset = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    chk("b_mrst_valid", 32'(b_out_valid), 32'd0);
    chk("b_mrst_count", 32'(b_out_count), 32'd0);
    chk("b_mrst_ready", 32'(b_in_ready), 32'd1);
    chk("b_mrst_immdt", 32'(b_out_immdt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
